// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if
//   Bundles the sequencer's request/instruction inputs and its datapath
//   control outputs so the control unit and its environment share one port.
//
//   Handshake: Run is a start request that is only looked at while the
//   sequencer sits in T0. The cycle in which IRin=1 is the acceptance of
//   that request, and DIN is captured on the clock edge that ends that cycle.
//   Done=1 for exactly one cycle marks retirement of the accepted
//   instruction. While an instruction is in flight (T1..T3), Run and DIN are
//   ignored.
//
//   Signals:
//     Run     request to fetch DIN (driven by master)
//     DIN     instruction word / immediate (driven by master)
//     IRin    DIN -> IR load strobe
//     Rin     one-hot register write enable
//     Rout    one-hot register bus-drive select
//     DINout  DIN drives the bus
//     Ain     load A from the bus
//     Gin     load G from the ALU
//     Gout    G drives the bus
//     ALUop   00 add, 01 sub, 10 and, 11 or
//     Done    one-cycle retire pulse
//     step    current step T0..T3 (debug view of the FSM)
//
//   Modports:
//     master  environment side (drives Run/DIN)
//     slave   control unit side
// -----------------------------------------------------------------------------
interface control_unit_if #(
  parameter int IR_W      = 9,
  parameter int REG_SEL_W = 3
);
  localparam int N = 2 ** REG_SEL_W;

  logic            Run;
  logic [IR_W-1:0] DIN;
  logic            IRin;
  logic [N-1:0]    Rin;
  logic [N-1:0]    Rout;
  logic            DINout;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic [1:0]      ALUop;
  logic            Done;
  logic [1:0]      step;

  modport master (
    output Run, DIN,
    input  IRin, Rin, Rout, DINout, Ain, Gin, Gout, ALUop, Done, step
  );

  modport slave (
    input  Run, DIN,
    output IRin, Rin, Rout, DINout, Ain, Gin, Gout, ALUop, Done, step
  );
endinterface

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multi-cycle instruction sequencer for the mult-processor datapath.
//   Fetches a III_XXX_YYY instruction from DIN when Run is high in T0, then
//   steps it through T1..T3 driving the register file, A, G, bus mux and ALU
//   controls. Done pulses for one cycle when the instruction retires.
//
//   Ports:
//     CLK  clock, all state updates on posedge
//     CLR  synchronous active-high reset (priority over everything)
//     bus  control_unit_if.slave: Run, DIN in; IRin, Rin, Rout, DINout,
//          Ain, Gin, Gout, ALUop, Done, step out
//
//   Configuration macro:
//     CU_LOGIC_OPS_EN  when defined, opcodes 100 (and) / 101 (or) run the
//                      4-step ALU sequence with ALUop 10 / 11. When not
//                      defined they retire as NOPs in T1 and ALUop[1]=0.
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int IR_W      = 9,
  parameter int REG_SEL_W = 3
) (
  input  logic         CLK,
  input  logic         CLR,
  control_unit_if.slave bus
);
  localparam int N = 2 ** REG_SEL_W;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
`ifdef CU_LOGIC_OPS_EN
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
`endif

  logic [1:0]      step_q, step_d;
  logic [IR_W-1:0] ir_q, ir_d;

  logic [2:0]           op;
  logic [REG_SEL_W-1:0] rx, ry;
  logic [N-1:0]         rx_oh, ry_oh;
  logic                 is_alu;
  logic [1:0]           alu_code;

  logic         irin_c, dinout_c, ain_c, gin_c, gout_c, done_c;
  logic [N-1:0] rin_c, rout_c;
  logic [1:0]   aluop_c;

  assign op    = ir_q[IR_W-1 -: 3];
  assign rx    = ir_q[2*REG_SEL_W-1 -: REG_SEL_W];
  assign ry    = ir_q[REG_SEL_W-1:0];
  assign rx_oh = {{(N-1){1'b0}}, 1'b1} << rx;
  assign ry_oh = {{(N-1){1'b0}}, 1'b1} << ry;

  // ALU opcodes 010..101 map onto ALUop 00..11 as {op[2], op[0]}.
`ifdef CU_LOGIC_OPS_EN
  assign is_alu   = (op == OP_ADD) || (op == OP_SUB) ||
                    (op == OP_AND) || (op == OP_OR);
  assign alu_code = {op[2], op[0]};
`else
  assign is_alu   = (op == OP_ADD) || (op == OP_SUB);
  assign alu_code = {1'b0, op[0]};
`endif

  always_comb begin
    step_d   = step_q;
    ir_d     = ir_q;
    irin_c   = 1'b0;
    rin_c    = '0;
    rout_c   = '0;
    dinout_c = 1'b0;
    ain_c    = 1'b0;
    gin_c    = 1'b0;
    gout_c   = 1'b0;
    aluop_c  = 2'b00;
    done_c   = 1'b0;

    case (step_q)
      T0: begin
        if (bus.Run) begin
          irin_c = 1'b1;
          ir_d   = bus.DIN;
          step_d = T1;
        end
      end
      T1: begin
        if (op == OP_MV) begin
          rout_c = ry_oh;
          rin_c  = rx_oh;
          done_c = 1'b1;
          step_d = T0;
        end else if (op == OP_MVI) begin
          dinout_c = 1'b1;
          rin_c    = rx_oh;
          done_c   = 1'b1;
          step_d   = T0;
        end else if (is_alu) begin
          rout_c = rx_oh;
          ain_c  = 1'b1;
          step_d = T2;
        end else begin
          // Illegal opcode: retire immediately without touching the datapath.
          done_c = 1'b1;
          step_d = T0;
        end
      end
      T2: begin
        rout_c  = ry_oh;
        gin_c   = 1'b1;
        aluop_c = alu_code;
        step_d  = T3;
      end
      default: begin // T3
        gout_c  = 1'b1;
        rin_c   = rx_oh;
        aluop_c = alu_code;
        done_c  = 1'b1;
        step_d  = T0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  // CLR silences every control in the cycle it is asserted, so an aborted
  // instruction can never write a register or retire, and no fetch is
  // acknowledged while reset is held.
  assign bus.IRin   = irin_c   & ~CLR;
  assign bus.Rin    = rin_c    & {N{~CLR}};
  assign bus.Rout   = rout_c   & {N{~CLR}};
  assign bus.DINout = dinout_c & ~CLR;
  assign bus.Ain    = ain_c    & ~CLR;
  assign bus.Gin    = gin_c    & ~CLR;
  assign bus.Gout   = gout_c   & ~CLR;
  assign bus.ALUop  = aluop_c  & {2{~CLR}};
  assign bus.Done   = done_c   & ~CLR;
  assign bus.step   = step_q;
endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  localparam int IR_W = 9;
  localparam int VW   = 26;

  logic CLK;
  logic CLR;

  control_unit_if #(.IR_W(IR_W), .REG_SEL_W(3)) bus ();

  control_unit #(.IR_W(IR_W), .REG_SEL_W(3)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [VW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  logic [VW-1:0] act_vec;
  assign act_vec = {bus.step, bus.IRin, bus.Rin, bus.Rout, bus.DINout,
                    bus.Ain, bus.Gin, bus.Gout, bus.ALUop, bus.Done};

  // Expected-vector builder; field order matches act_vec.
  function automatic logic [VW-1:0] ev(
    input logic [1:0] stp, input logic irin, input logic [7:0] rin,
    input logic [7:0] rout, input logic dinout, input logic ain,
    input logic gin, input logic gout, input logic [1:0] aluop,
    input logic done);
    return {stp, irin, rin, rout, dinout, ain, gin, gout, aluop, done};
  endfunction

  // ---------------- driver ----------------
  // Drive inputs just after the active edge and queue what the DUT must
  // show for the rest of this cycle.
  task automatic cyc(input logic clr, input logic run, input logic [IR_W-1:0] din,
                     input logic [VW-1:0] exp_v, input string nm);
    @(posedge CLK);
    #1;
    CLR     = clr;
    bus.Run = run;
    bus.DIN = din;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e;
      string         nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act_vec === e) n_pass++;
      else $display("FAIL %s: got %h expected %h (step,IRin,Rin,Rout,DINout,Ain,Gin,Gout,ALUop,Done)",
                    nm, act_vec, e);
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [IR_W-1:0] MVI_R3   = 9'b001_011_000;
  localparam logic [IR_W-1:0] ADD_R1R2 = 9'b010_001_010;
  localparam logic [IR_W-1:0] MV_R0R7  = 9'b000_000_111;
  localparam logic [IR_W-1:0] SUB_R5R5 = 9'b011_101_101;
  localparam logic [IR_W-1:0] AND_R2R1 = 9'b100_010_001;
  localparam logic [IR_W-1:0] ILL_111  = 9'b111_001_001;

  initial begin
    CLR     = 1'b1;
    bus.Run = 1'b1;
    bus.DIN = MVI_R3;

    // Reset held with Run high: no fetch acknowledged.
    cyc(1, 1, MVI_R3, ev(0,0,0,0,0,0,0,0,0,0), "rst_c0");
    cyc(1, 1, MVI_R3, ev(0,0,0,0,0,0,0,0,0,0), "rst_c1");

    // mvi R3
    cyc(0, 1, MVI_R3, ev(0,1,0,0,0,0,0,0,0,0), "mvi_t0");
    cyc(0, 0, 9'h0,   ev(1,0,8'h08,0,1,0,0,0,0,1), "mvi_t1");
    cyc(0, 0, 9'h0,   ev(0,0,0,0,0,0,0,0,0,0), "idle_a");

    // add R1,R2
    cyc(0, 1, ADD_R1R2, ev(0,1,0,0,0,0,0,0,0,0), "add_t0");
    cyc(0, 0, 9'h0,     ev(1,0,0,8'h02,0,1,0,0,0,0), "add_t1");
    cyc(0, 1, 9'h1ff,   ev(2,0,0,8'h04,0,0,1,0,2'b00,0), "add_t2");
    cyc(0, 1, 9'h1ff,   ev(3,0,8'h02,0,0,0,0,1,2'b00,1), "add_t3");
    cyc(0, 0, 9'h0,     ev(0,0,0,0,0,0,0,0,0,0), "idle_b");

    // Back-to-back: mv R0,R7 then sub R5,R5 with Run held high.
    cyc(0, 1, MV_R0R7,  ev(0,1,0,0,0,0,0,0,0,0), "b2b_mv_t0");
    cyc(0, 1, SUB_R5R5, ev(1,0,8'h01,8'h80,0,0,0,0,0,1), "b2b_mv_t1");
    cyc(0, 1, SUB_R5R5, ev(0,1,0,0,0,0,0,0,0,0), "b2b_sub_t0");
    cyc(0, 1, MV_R0R7,  ev(1,0,0,8'h20,0,1,0,0,0,0), "b2b_sub_t1");
    cyc(0, 1, MV_R0R7,  ev(2,0,0,8'h20,0,0,1,0,2'b01,0), "b2b_sub_t2");
    cyc(0, 1, MV_R0R7,  ev(3,0,8'h20,0,0,0,0,1,2'b01,1), "b2b_sub_t3");
    cyc(0, 0, 9'h0,     ev(0,0,0,0,0,0,0,0,0,0), "idle_c");

    // CLR in T2 of add: everything silenced, then back in idle T0.
    cyc(0, 1, ADD_R1R2, ev(0,1,0,0,0,0,0,0,0,0), "abort_t0");
    cyc(0, 0, 9'h0,     ev(1,0,0,8'h02,0,1,0,0,0,0), "abort_t1");
    cyc(1, 0, 9'h0,     ev(2,0,0,0,0,0,0,0,0,0), "abort_clr_t2");
    cyc(0, 0, 9'h0,     ev(0,0,0,0,0,0,0,0,0,0), "abort_after");
    cyc(0, 0, 9'h0,     ev(0,0,0,0,0,0,0,0,0,0), "abort_idle");

    // Opcode 100 (and R2,R1)
    cyc(0, 1, AND_R2R1, ev(0,1,0,0,0,0,0,0,0,0), "op100_t0");
`ifdef CU_LOGIC_OPS_EN
    cyc(0, 0, 9'h0, ev(1,0,0,8'h04,0,1,0,0,0,0), "op100_t1");
    cyc(0, 0, 9'h0, ev(2,0,0,8'h02,0,0,1,0,2'b10,0), "op100_t2");
    cyc(0, 0, 9'h0, ev(3,0,8'h04,0,0,0,0,1,2'b10,1), "op100_t3");
`else
    cyc(0, 0, 9'h0, ev(1,0,0,0,0,0,0,0,0,1), "op100_nop_t1");
`endif
    cyc(0, 0, 9'h0, ev(0,0,0,0,0,0,0,0,0,0), "idle_d");

    // Opcode 111 is always an illegal-op NOP.
    cyc(0, 1, ILL_111, ev(0,1,0,0,0,0,0,0,0,0), "ill_t0");
    cyc(0, 0, 9'h0,    ev(1,0,0,0,0,0,0,0,0,1), "ill_t1");
    cyc(0, 0, 9'h0,    ev(0,0,0,0,0,0,0,0,0,0), "idle_e");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
